pe_mac_pipe: RTL and testbench
==============================

// Module: pe_mac_pipe
// PURPOSE
//  Parametrised pipelined floating-point multiply-accumulate processing element for the conv layer.
//  Multiplies floatA*floatB per accepted pair and accumulates ACC_LEN products (one kernel window).
//  Emits the sum with a valid/ready handshake and restarts accumulation automatically.
//  Generalises the fixed 16-bit PE: configurable exponent/mantissa widths, group length, backpressure.
// PARAMETERS
//  EXP_W    5   exponent field width (5 = IEEE half)
//  MAN_W    10  mantissa field width, hidden bit excluded (10 = IEEE half)
//  ACC_LEN  9   products per output; 9 = 3x3 kernel; legal range 1..65535
//  (derived) W = 1+EXP_W+MAN_W; CNT_W = $clog2(ACC_LEN+1)
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-low reset (0 = reset)
//  in_valid   in   1    floatA/floatB pair valid
//  in_ready   out  1    PE can accept a pair this cycle
//  floatA     in   W    operand A (sign|exp|man)
//  floatB     in   W    operand B
//  out_valid  out  1    result holds a completed ACC_LEN sum
//  out_ready  in   1    consumer accepts result
//  result     out  W    accumulated sum
//  ovf        out  1    sticky per group: some product/sum saturated to infinity; qualified by out_valid
// BEHAVIOUR
//  Reset (reset=0, async): out_valid=0, result=0, ovf=0, accumulator=+0, count=0, pipeline valids=0; in_ready=1 after release.
//  stall = out_valid & ~out_ready; in_ready = ~stall. While stall, all pipeline regs hold.
//  Accept = in_valid & in_ready. Stage 1 (edge after accept): registered product + valid bit.
//  Stage 2 (next edge): acc <= acc + product; count <= count+1.
//  On the ACC_LEN-th product: result <= acc+product, ovf <= group ovf, out_valid <= 1, acc <= +0, count <= 0, same edge.
//  Latency: last pair accepted at edge t -> out_valid=1 after edge t+2. Throughput 1 pair/cycle without stall.
//  out_valid clears on the edge where out_valid & out_ready; a new result may load on that same edge (back-to-back).
//  Next group's products flow into the pipeline while the previous result waits; no pair is lost or duplicated.
//  Arithmetic: exponent bias 2^(EXP_W-1)-1; round toward zero (truncate); subnormal inputs/results flush to +0.
//  Exponent overflow -> signed infinity (exp all 1s, man 0) and ovf set; infinity input propagates; NaN unsupported.
//  Exact zero sum is +0. Product of zero operand is +0.
//  Reset mid-group discards the partial sum, in-flight products and any pending result.
// CONFIGURATION
//  PE_RELU_EN defined: the result register loads max(sum,0): negative sums (including -inf) load +0; ovf unaffected.
//  PE_RELU_EN undefined: result loads the signed sum unchanged.
// TESTING (EXP_W=5, MAN_W=10)
//  ACC_LEN=1: A=0x4000 (2), B=0x4200 (3) -> out_valid 2 cycles after accept, result=0x4600 (6.0), ovf=0.
//  ACC_LEN=9: nine back-to-back 0x3C00*0x3C00 -> single result 0x4880 (9.0); next group starts at 0.
//  ACC_LEN=1: A=0xC000 (-2), B=0x4200 -> result 0xC600; with PE_RELU_EN -> 0x0000.
//  ACC_LEN=1: A=B=0x7BFF -> result 0x7C00 (+inf), ovf=1; following group ovf=0.
//  ACC_LEN=1, out_ready=0 for 5 cycles, in_valid=1 continuous -> in_ready=0 while held, results in order, none lost.
//  ACC_LEN=9: reset=0 after 4 pairs, resume with 9 pairs of 0x3C00 -> result 0x4880 (no stale partials).

Source files
------------

// File: rtl/pe_mac_pipe.sv
// Pipelined floating-point multiply-accumulate PE: ACC_LEN products per result, valid/ready output.
// Optional PE_RELU_EN: the result register loads max(sum, 0).
module pe_mac_pipe #(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10,
  parameter int ACC_LEN = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   floatA,
  input  logic [EXP_W+MAN_W:0]   floatB,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(ACC_LEN + 1);
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int PW    = 2 * MAN_W + 2;
  localparam int XW    = MAN_W + 4;  // hidden + mantissa + two guard bits + sticky
  localparam logic [EXP_W-1:0] EXP_INF  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  typedef struct packed {
    logic         ovf;
    logic [W-1:0] val;
  } fp_res_t;

  function automatic fp_res_t fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    fp_res_t            r;
    logic               s;
    logic [PW-1:0]      p;
    logic [MAN_W-1:0]   man;
    int                 e;
    r = '0;
    s = a[W-1] ^ b[W-1];
    if (a[W-2:MAN_W] == '0 || b[W-2:MAN_W] == '0) begin
      r = '0;
    end else if (a[W-2:MAN_W] == EXP_INF || b[W-2:MAN_W] == EXP_INF) begin
      r.val = {s, EXP_INF, {MAN_W{1'b0}}};
    end else begin
      p = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
      e = int'(a[W-2:MAN_W]) + int'(b[W-2:MAN_W]) - BIAS;
      if (p[PW-1]) begin
        e   = e + 1;
        man = p[PW-2 -: MAN_W];
      end else begin
        man = p[PW-3 -: MAN_W];
      end
      if (e >= EMAX) begin
        r.ovf = 1'b1;
        r.val = {s, EXP_INF, {MAN_W{1'b0}}};
      end else if (e <= 0) begin
        r = '0;
      end else begin
        r.val = {s, e[EXP_W-1:0], man};
      end
    end
    return r;
  endfunction

  // Truncating add. With inf on both sides (NaN case) the left operand wins.
  function automatic fp_res_t fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
    fp_res_t            r;
    logic [W-1:0]       bg, sm;
    logic [XW-1:0]      bx, sx, dif;
    logic [2*XW-1:0]    sh;
    logic [XW:0]        sum;
    logic [MAN_W-1:0]   man;
    int                 d, e, lz;
    r = '0;
    if (a[W-2:MAN_W] == '0 && b[W-2:MAN_W] == '0) begin
      r = '0;
    end else if (a[W-2:MAN_W] == '0) begin
      r.val = b;
    end else if (b[W-2:MAN_W] == '0) begin
      r.val = a;
    end else if (a[W-2:MAN_W] == EXP_INF) begin
      r.val = a;
    end else if (b[W-2:MAN_W] == EXP_INF) begin
      r.val = b;
    end else begin
      if (a[W-2:0] >= b[W-2:0]) begin
        bg = a; sm = b;
      end else begin
        bg = b; sm = a;
      end
      d  = int'(bg[W-2:MAN_W]) - int'(sm[W-2:MAN_W]);
      bx = {1'b1, bg[MAN_W-1:0], 3'b000};
      sx = {1'b1, sm[MAN_W-1:0], 3'b000};
      // Everything shifted below the LSB collapses into it as a sticky bit,
      // which keeps truncation exact for both add and subtract.
      if (d >= 2 * XW) begin
        sx = {{(XW-1){1'b0}}, 1'b1};
      end else begin
        sh = {sx, {XW{1'b0}}} >> d;
        sx = {sh[2*XW-1:XW+1], sh[XW] | (|sh[XW-1:0])};
      end
      if (bg[W-1] == sm[W-1]) begin
        sum = {1'b0, bx} + {1'b0, sx};
        e   = int'(bg[W-2:MAN_W]);
        if (sum[XW]) begin
          e   = e + 1;
          man = sum[XW-1 -: MAN_W];
        end else begin
          man = sum[XW-2 -: MAN_W];
        end
        if (e >= EMAX) begin
          r.ovf = 1'b1;
          r.val = {bg[W-1], EXP_INF, {MAN_W{1'b0}}};
        end else begin
          r.val = {bg[W-1], e[EXP_W-1:0], man};
        end
      end else begin
        dif = bx - sx;
        lz  = 0;
        for (int i = 0; i < XW; i++) if (dif[i]) lz = XW - 1 - i;
        e = int'(bg[W-2:MAN_W]) - lz;
        if (dif == '0 || e <= 0) begin
          r = '0;
        end else begin
          dif   = dif << lz;
          r.val = {bg[W-1], e[EXP_W-1:0], dif[XW-2 -: MAN_W]};
        end
      end
    end
    return r;
  endfunction

  logic             stall;
  fp_res_t          mul_r, add_r;
  logic             prod_vld_q, prod_vld_d;
  logic [W-1:0]     prod_q, prod_d;
  logic             prod_ovf_q, prod_ovf_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grp_ovf_q, grp_ovf_d;
  logic [W-1:0]     res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             out_vld_q, out_vld_d;

  assign stall     = out_vld_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_vld_q;
  assign result    = res_q;
  assign ovf       = ovf_q;

  always_comb begin
    mul_r      = fp_mul(floatA, floatB);
    add_r      = fp_add(acc_q, prod_q);
    prod_vld_d = prod_vld_q;
    prod_d     = prod_q;
    prod_ovf_d = prod_ovf_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    grp_ovf_d  = grp_ovf_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    out_vld_d  = out_vld_q;
    if (!stall) begin
      prod_vld_d = in_valid;
      if (in_valid) begin
        prod_d     = mul_r.val;
        prod_ovf_d = mul_r.ovf;
      end
      if (out_vld_q && out_ready) out_vld_d = 1'b0;
      if (prod_vld_q) begin
        if (cnt_q == CNT_LAST) begin
`ifdef PE_RELU_EN
          res_d = add_r.val[W-1] ? '0 : add_r.val;
`else
          res_d = add_r.val;
`endif
          ovf_d     = grp_ovf_q | prod_ovf_q | add_r.ovf;
          out_vld_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          grp_ovf_d = 1'b0;
        end else begin
          acc_d     = add_r.val;
          cnt_d     = cnt_q + 1'b1;
          grp_ovf_d = grp_ovf_q | prod_ovf_q | add_r.ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      prod_ovf_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      grp_ovf_q  <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      prod_ovf_q <= prod_ovf_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      grp_ovf_q  <= grp_ovf_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      out_vld_q  <= out_vld_d;
    end
  end
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe (half precision): ACC_LEN=1 and ACC_LEN=9 instances checked against a
// real-arithmetic model with truncation, plus directed cases and literal pins on the model.
module tb_pe_mac_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [15:0] a, b;
  logic        rdy1, rdy9, ov1, ov9, of1, of9;
  logic [15:0] res1, res9;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  pe_mac_pipe #(.EXP_W(5), .MAN_W(10), .ACC_LEN(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .floatA(a), .floatB(b),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .ovf(of1));
  pe_mac_pipe #(.EXP_W(5), .MAN_W(10), .ACC_LEN(9)) u9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy9), .floatA(a), .floatB(b),
    .out_valid(ov9), .out_ready(out_ready), .result(res9), .ovf(of9));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---- behavioural half-precision model: exact reals, truncated on encode ----
  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real dec(input logic [15:0] x);
    real v;
    if (x[14:10] == 5'd0) return 0.0;
    v = p2(int'(x[14:10]) - 15) * (1.0 + real'(x[9:0]) / 1024.0);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [16:0] enc(input real v);
    real  m;
    int   e, man;
    logic s;
    if (v == 0.0) return 17'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    e = e + 15;
    if (e >= 31) return {1'b1, s, 5'h1f, 10'h0};
    if (e <= 0) return 17'h0;
    man = $rtoi((m - 1.0) * 1024.0);
    return {1'b0, s, e[4:0], man[9:0]};
  endfunction

  function automatic logic [16:0] mmul(input logic [15:0] x, input logic [15:0] y);
    if (x[14:10] == 5'd0 || y[14:10] == 5'd0) return 17'h0;
    if (x[14:10] == 5'h1f || y[14:10] == 5'h1f) return {1'b0, x[15] ^ y[15], 5'h1f, 10'h0};
    return enc(dec(x) * dec(y));
  endfunction

  function automatic logic [16:0] madd(input logic [15:0] x, input logic [15:0] y);
    if (x[14:10] == 5'h1f) return {1'b0, x};
    if (y[14:10] == 5'h1f) return {1'b0, y};
    return enc(dec(x) + dec(y));
  endfunction

  // ---- per-instance group state and expected-result queues (index 0: ACC_LEN=1, 1: ACC_LEN=9) ----
  logic [15:0] m_acc [2];
  int          m_cnt [2];
  logic        m_govf[2];
  int          nacc  [2];
  int          npop  [2];
  logic [15:0] last_res[2];
  logic        last_ovf[2];
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 16'h0; m_cnt[k] = 0; m_govf[k] = 1'b0;
      nacc[k] = 0; npop[k] = 0; last_res[k] = 16'hxxxx; last_ovf[k] = 1'bx;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_accept(input int k, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] p, s;
    logic [15:0] r;
    logic        ov;
    p  = mmul(x, y);
    s  = madd(m_acc[k], p[15:0]);
    ov = m_govf[k] | p[16] | s[16];
    nacc[k]++;
    m_cnt[k]++;
    if (m_cnt[k] == ((k == 0) ? 1 : 9)) begin
      r = s[15:0];
`ifdef PE_RELU_EN
      if (r[15]) r = 16'h0;
`endif
      if (k == 0) q0.push_back({ov, r});
      else q1.push_back({ov, r});
      m_acc[k] = 16'h0; m_cnt[k] = 0; m_govf[k] = 1'b0;
    end else begin
      m_acc[k] = s[15:0]; m_govf[k] = ov;
    end
  endtask

  task automatic take_out(input int k, input logic [15:0] r, input logic o);
    logic [16:0] e;
    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_out inst=%0d actual=%h expected=none", k, r);
    end else begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("result[%0d]", k), r, e[15:0]);
      chk($sformatf("ovf[%0d]", k), o, e[16]);
      last_res[k] = r; last_ovf[k] = o; npop[k]++;
    end
  endtask

  // Compare process: inputs change just after posedge, so negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready1", rdy1, !(ov1 && !out_ready));
      chk("in_ready9", rdy9, !(ov9 && !out_ready));
      if (in_valid && rdy1) model_accept(0, a, b);
      if (in_valid && rdy9) model_accept(1, a, b);
      if (ov1 && out_ready) take_out(0, res1, of1);
      if (ov9 && out_ready) take_out(1, res9, of9);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_ov", {ov1, ov9}, 2'b00);
    chk("rst_res", {res1, res9}, 32'h0);
    chk("rst_ovf", {of1, of9}, 2'b00);
    reset = 1'b1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input int n);
    for (int i = 0; i < n; i++) begin
      a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_op();
    logic [31:0] r;
    logic [4:0]  e;
    r = $urandom;
    case (r[5:0])
      6'd0:                   e = 5'd0;
      6'd1:                   e = 5'h1f;
      6'd2, 6'd3, 6'd4, 6'd5: e = 5'(26 + int'(r[7:6]));
      default:                e = 5'(8 + 2 * int'(r[10:8]));
    endcase
    return {r[31], e, (e == 5'h1f) ? 10'h0 : r[25:16]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; a = 16'h0; b = 16'h0; out_ready = 1'b1;
    model_clear();

    // literal pins on the model itself
    chk("pin_mul_2x3", mmul(16'h4000, 16'h4200), 17'h04600);
    chk("pin_mul_neg", mmul(16'hC000, 16'h4200), 17'h0C600);
    chk("pin_mul_ovf", mmul(16'h7BFF, 16'h7BFF), 17'h17C00);
    chk("pin_mul_trunc", mmul(16'h3C01, 16'h3C01), 17'h03C02);
    chk("pin_add_sub_trunc", madd(16'h3C00, 16'h8C00), 17'h03BFF);
    chk("pin_add_cancel", madd(16'h3C00, 16'hBC00), 17'h00000);

    repeat (3) @(posedge clk); #1;
    chk("rst_ov_init", {ov1, ov9}, 2'b00);
    chk("rst_res_init", {res1, res9}, 32'h0);
    chk("rst_ovf_init", {of1, of9}, 2'b00);
    reset = 1'b1;
    #1 chk("rdy_after_rst", {rdy1, rdy9}, 2'b11);

    // 2*3, latency of two edges
    a = 16'h4000; b = 16'h4200; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("lat_stage1_ov", ov1, 1'b0);
    @(posedge clk); #1;
    chk("lat_stage2_ov", ov1, 1'b1);
    chk("lat_res", res1, 16'h4600);
    chk("lat_ovf", of1, 1'b0);
    repeat (2) @(posedge clk); #1;

    // negative product
    do_reset();
    send(16'hC000, 16'h4200, 1);
    repeat (3) @(posedge clk); #1;
`ifdef PE_RELU_EN
    chk("neg_res", last_res[0], 16'h0000);
`else
    chk("neg_res", last_res[0], 16'hC600);
`endif

    // overflow, then a clean group
    do_reset();
    send(16'h7BFF, 16'h7BFF, 1);
    repeat (3) @(posedge clk); #1;
    chk("ovf_res", last_res[0], 16'h7C00);
    chk("ovf_flag", last_ovf[0], 1'b1);
    send(16'h3C00, 16'h3C00, 1);
    repeat (3) @(posedge clk); #1;
    chk("ovf_next_flag", last_ovf[0], 1'b0);
    chk("ovf_next_res", last_res[0], 16'h3C00);

    // nine ones, twice
    do_reset();
    send(16'h3C00, 16'h3C00, 9);
    repeat (3) @(posedge clk); #1;
    chk("nine_res", last_res[1], 16'h4880);
    chk("nine_count", npop[1], 1);
    send(16'h3C00, 16'h3C00, 9);
    repeat (3) @(posedge clk); #1;
    chk("nine2_res", last_res[1], 16'h4880);
    chk("nine2_count", npop[1], 2);

    // reset mid-group discards partials
    do_reset();
    send(16'h3C00, 16'h3C00, 4);
    do_reset();
    send(16'h3C00, 16'h3C00, 9);
    repeat (3) @(posedge clk); #1;
    chk("midrst_res", last_res[1], 16'h4880);
    chk("midrst_count", npop[1], 1);

    // backpressure with continuous input
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a = {1'b0, 5'(15 + i), 10'h0}; b = 16'h3C00; in_valid = 1'b1;
      out_ready = (i >= 5);
      @(posedge clk); #1;
      if (i == 3) chk("stall_in_ready", rdy1, 1'b0);
      if (i == 3) chk("stall_out_valid", ov1, 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("stall_none_lost", npop[0], nacc[0]);
    chk("stall_q_empty", q0.size(), 0);

    // randomized traffic with a reset in the middle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      a = rnd_op(); b = rnd_op();
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk); #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_pops0", npop[0], nacc[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
